csr_wport_arbiter: RTL and testbench
====================================

Name: csr_wport_arbiter

Overview:
- Shares the single CSR register-file write port between two sources: the trap/CSR sequencer in the interrupt controller, and WB-stage CSR instructions (csrrw/csrrs/csrrc).
- Trap writes have absolute priority. Pipeline writes that lose arbitration are queued in a small in-order buffer and issued later.
- Forwards pending (not yet written) CSR values to the read side.
- Reports when the port is fully drained, so the trap sequencer never samples stale mstatus/mie/mtvec.

Parameters:
DEPTH, 2, pipeline write buffer entries (power of two, ≥2)
ADDR_W, 12, CSR address width
DATA_W, 32, CSR data width

Ports:
clk  in  1  clock
rst  in  1  reset
trap_we_i  in  1  sequencer write strobe; never back-pressured
trap_waddr_i  in  ADDR_W  sequencer write address
trap_wdata_i  in  DATA_W  sequencer write data
trap_busy_i  in  1  sequencer FSM not idle
wb_we_i  in  1  WB CSR write valid
wb_waddr_i  in  ADDR_W  WB write address
wb_wdata_i  in  DATA_W  WB write data
wb_ready_o  out  1  WB write accepted this cycle
rd_addr_i  in  ADDR_W  CSR read address to check for pending data
fwd_hit_o  out  1  a pending write matches rd_addr_i
fwd_data_o  out  DATA_W  data of the youngest matching pending write
csr_we_o  out  1  register-file write enable (registered)
csr_waddr_o  out  ADDR_W  register-file write address (registered)
csr_wdata_o  out  DATA_W  register-file write data (registered)
grant_src_o  out  2  source of the current output: 00 none, 01 trap, 10 WB direct, 11 buffer
drained_o  out  1  buffer empty and csr_we_o low
stall_req_o  out  1  buffer full; feeds pipeline control
proto_err_o  out  1  sticky: wb_we_i seen while wb_ready_o low

Behaviour:
- Clock and reset: clk is the single clock. rst is asynchronous, active-high.
- Reset state: all outputs 0, except wb_ready_o=1 and drained_o=1. Buffer count=0, FSM=IDLE.
- Reset mid-operation: all buffered entries and any in-flight output are discarded.
- Latency: the selected write appears on csr_* exactly one cycle after selection. The register file commits it on the following edge.
- Selection priority each cycle:
  - trap_we_i first.
  - Then the buffer head, if count>0.
  - Then wb_we_i directly, only if count==0 (preserves program order).
- Enqueue: a WB write is pushed when wb_we_i && wb_ready_o and it is not selected this cycle.
- Push and pop in the same cycle: count unchanged, order preserved.
- wb_ready_o = (count != DEPTH).
  - Based on count only; a same-cycle pop does not free the slot early.
- stall_req_o = (count == DEPTH).
- FSM (3 states):
  - IDLE: count==0 and no trap activity.
  - TRAP: trap_busy_i || trap_we_i. The buffer only accepts pushes, no pops.
  - DRAIN: count>0 and no trap activity. Pops one entry per cycle.
  - IDLE→TRAP on trap_busy_i or trap_we_i.
  - IDLE→DRAIN when a WB write is pushed.
  - TRAP→DRAIN when the trap ends and count>0.
  - TRAP→IDLE when the trap ends and count==0.
  - DRAIN→IDLE when the last entry is popped and there is no push.
  - DRAIN→TRAP on trap_busy_i or trap_we_i.
- Forwarding (combinational on rd_addr_i):
  - Searches buffer entries youngest first, then the csr_* output register.
  - Incoming same-cycle writes are not forwarded.
  - fwd_data_o = 0 when there is no hit.
- Trap writes are never enqueued: trap_we_i with a full buffer still issues.
- drained_o is combinational from registered state.
- proto_err_o:
  - Sets on wb_we_i && !wb_ready_o; the offending write is dropped.
  - Clears only on rst.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset with rst high mid-DRAIN, buffer holding 2 entries → next cycle all csr_* = 0, drained_o=1, wb_ready_o=1, count=0.
- WB write to 0x305 with data 0x80000100, idle → csr_we_o=1, csr_waddr_o=0x305, grant_src_o=10 one cycle later; drained_o=1 the cycle after that.
- Same cycle: trap_we_i to 0x341 with data 0x80000040, and WB write to 0x300 with data 0x8 → cycle+1 trap write issued (01); cycle+2 0x300 issued from buffer (11).
- trap_busy_i held 5 cycles while 3 WB writes arrive with DEPTH=2 → first two accepted, stall_req_o=1, wb_ready_o=0 during the third; if the third is still driven, proto_err_o=1. After trap_busy_i falls, the two writes issue in order on consecutive cycles.
- Two buffered writes to 0x300 (data 0x8, then 0x88) and rd_addr_i=0x300 → fwd_hit_o=1, fwd_data_o=0x88; rd_addr_i=0x304 → fwd_hit_o=0, fwd_data_o=0.
- Push and pop in the same cycle for 2·DEPTH+1 cycles → count constant, issue order matches arrival order across pointer wrap.

Source files
------------

// File: rtl/csr_wport_arbiter_if.sv
// csr_wport_arbiter_if
//   Bundles every signal of the CSR write-port arbiter except clk/rst.
//   slave  : the arbiter side (takes trap/WB writes, drives the register file)
//   master : the surrounding logic (trap sequencer, WB stage, read side, RF)
//   Trap side : trap_we_i, trap_waddr_i, trap_wdata_i, trap_busy_i
//   WB side   : wb_we_i, wb_waddr_i, wb_wdata_i, wb_ready_o
//   Read side : rd_addr_i, fwd_hit_o, fwd_data_o
//   RF side   : csr_we_o, csr_waddr_o, csr_wdata_o, grant_src_o
//   Status    : drained_o, stall_req_o, proto_err_o
interface csr_wport_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              trap_we_i;
    logic [ADDR_W-1:0] trap_waddr_i;
    logic [DATA_W-1:0] trap_wdata_i;
    logic              trap_busy_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_waddr_i;
    logic [DATA_W-1:0] wb_wdata_i;
    logic              wb_ready_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              fwd_hit_o;
    logic [DATA_W-1:0] fwd_data_o;
    logic              csr_we_o;
    logic [ADDR_W-1:0] csr_waddr_o;
    logic [DATA_W-1:0] csr_wdata_o;
    logic [1:0]        grant_src_o;
    logic              drained_o;
    logic              stall_req_o;
    logic              proto_err_o;

    modport slave (
        input  trap_we_i, trap_waddr_i, trap_wdata_i, trap_busy_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i, rd_addr_i,
        output wb_ready_o, fwd_hit_o, fwd_data_o,
        output csr_we_o, csr_waddr_o, csr_wdata_o, grant_src_o,
        output drained_o, stall_req_o, proto_err_o
    );

    modport master (
        output trap_we_i, trap_waddr_i, trap_wdata_i, trap_busy_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i, rd_addr_i,
        input  wb_ready_o, fwd_hit_o, fwd_data_o,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, grant_src_o,
        input  drained_o, stall_req_o, proto_err_o
    );
endinterface

// File: rtl/csr_wport_arbiter.sv
// csr_wport_arbiter
//   Shares the single CSR register-file write port between the trap
//   sequencer (absolute priority, never back-pressured) and WB-stage CSR
//   instructions. WB writes that cannot issue are held in an in-order
//   buffer of DEPTH entries and drained when no trap activity is present.
//   Ports: clk, rst (async, active-high), bus (csr_wport_arbiter_if.slave).
//
//   state | meaning
//   IDLE  | buffer empty, no trap activity
//   TRAP  | trap_busy_i or trap_we_i; buffer accepts pushes only
//   DRAIN | buffer non-empty, no trap activity; one pop per cycle
module csr_wport_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    csr_wport_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_TRAP = 2'b01;
    localparam logic [1:0] SRC_WB   = 2'b10;
    localparam logic [1:0] SRC_BUF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];

    logic              csr_we_q;
    logic [ADDR_W-1:0] csr_waddr_q;
    logic [DATA_W-1:0] csr_wdata_q;
    logic [1:0]        src_q;
    logic              perr_q;

    logic              trap_act;
    logic              wb_ready;
    logic              push, pop;
    logic [1:0]        sel_src;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;

    assign trap_act = bus.trap_we_i | bus.trap_busy_i;
    // Readiness looks at the registered count only, so a same-cycle pop
    // never frees a slot early.
    assign wb_ready = (count_q != FULL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trap_act)
                    state_d = TRAP;
                else if (push)
                    state_d = DRAIN;
            end
            TRAP: begin
                if (!trap_act)
                    state_d = (count_d != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (trap_act)
                    state_d = TRAP;
                else if (count_d == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: source selection, push/pop strobes
    always_comb begin
        sel_src = SRC_NONE;
        pop     = 1'b0;
        if (bus.trap_we_i) begin
            sel_src = SRC_TRAP;
        end else if (!bus.trap_busy_i) begin
            if (count_q != '0) begin
                sel_src = SRC_BUF;
                pop     = 1'b1;
            end else if (bus.wb_we_i) begin
                // Direct issue only with an empty buffer keeps program order.
                sel_src = SRC_WB;
            end
        end
        push = bus.wb_we_i && wb_ready && (sel_src != SRC_WB);
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            src_q       <= SRC_NONE;
            perr_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (bus.wb_we_i && !wb_ready)
                perr_q <= 1'b1;
            csr_we_q <= (sel_src != SRC_NONE);
            src_q    <= sel_src;
            unique case (sel_src)
                SRC_TRAP: begin
                    csr_waddr_q <= bus.trap_waddr_i;
                    csr_wdata_q <= bus.trap_wdata_i;
                end
                SRC_WB: begin
                    csr_waddr_q <= bus.wb_waddr_i;
                    csr_wdata_q <= bus.wb_wdata_i;
                end
                SRC_BUF: begin
                    csr_waddr_q <= buf_addr[rd_ptr_q];
                    csr_wdata_q <= buf_data[rd_ptr_q];
                end
                default: begin
                    csr_waddr_q <= '0;
                    csr_wdata_q <= '0;
                end
            endcase
        end
    end

    // Entry storage needs no reset; validity comes from count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= bus.wb_waddr_i;
            buf_data[wr_ptr_q] <= bus.wb_wdata_i;
        end
    end

    // Forwarding: output register is the oldest pending write; buffer
    // entries are scanned oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (csr_we_q && (csr_waddr_q == bus.rd_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = csr_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (buf_addr[fwd_idx] == bus.rd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[fwd_idx];
            end
        end
    end

    assign bus.wb_ready_o  = wb_ready;
    assign bus.stall_req_o = (count_q == FULL);
    assign bus.drained_o   = (count_q == '0) && !csr_we_q;
    assign bus.fwd_hit_o   = fwd_hit;
    assign bus.fwd_data_o  = fwd_data;
    assign bus.csr_we_o    = csr_we_q;
    assign bus.csr_waddr_o = csr_waddr_q;
    assign bus.csr_wdata_o = csr_wdata_q;
    assign bus.grant_src_o = src_q;
    assign bus.proto_err_o = perr_q;

endmodule

// File: tb/tb_csr_wport_arbiter.sv
// tb_csr_wport_arbiter
//   Queue-based reference model of the write-port arbiter, compared against
//   the DUT on every falling edge, plus directed scenarios with literal
//   expectations and a randomized phase.
module tb_csr_wport_arbiter;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;

    csr_wport_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    csr_wport_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: pending queue plus the registered output write
    ent_t              q[$];
    logic              m_we   = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [1:0]        m_src  = 2'b00;
    logic              m_perr = 1'b0;
    bit                m_ready, m_took;
    ent_t              m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 2'b00; m_perr = 1'b0;
        end else begin
            m_ready = (q.size() != DEPTH);
            m_took  = 1'b0;
            if (bus.wb_we_i && !m_ready)
                m_perr = 1'b1;
            m_we = 1'b1;
            if (bus.trap_we_i) begin
                m_addr = bus.trap_waddr_i; m_data = bus.trap_wdata_i; m_src = 2'b01;
            end else if (!bus.trap_busy_i && q.size() > 0) begin
                m_e = q.pop_front();
                m_addr = m_e.a; m_data = m_e.d; m_src = 2'b11;
            end else if (!bus.trap_busy_i && bus.wb_we_i) begin
                m_addr = bus.wb_waddr_i; m_data = bus.wb_wdata_i; m_src = 2'b10;
                m_took = 1'b1;
            end else begin
                m_we = 1'b0; m_addr = '0; m_data = '0; m_src = 2'b00;
            end
            if (bus.wb_we_i && m_ready && !m_took)
                q.push_back('{a: bus.wb_waddr_i, d: bus.wb_wdata_i});
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (check_en) begin
            bit                e_hit;
            logic [DATA_W-1:0] e_fd;
            e_hit = 1'b0;
            e_fd  = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!e_hit && q[i].a == bus.rd_addr_i) begin
                    e_hit = 1'b1;
                    e_fd  = q[i].d;
                end
            end
            if (!e_hit && m_we && m_addr == bus.rd_addr_i) begin
                e_hit = 1'b1;
                e_fd  = m_data;
            end
            chk("csr_we",    64'(bus.csr_we_o),    64'(m_we));
            chk("csr_waddr", 64'(bus.csr_waddr_o), 64'(m_addr));
            chk("csr_wdata", 64'(bus.csr_wdata_o), 64'(m_data));
            chk("grant_src", 64'(bus.grant_src_o), 64'(m_src));
            chk("wb_ready",  64'(bus.wb_ready_o),  64'(q.size() != DEPTH));
            chk("stall_req", 64'(bus.stall_req_o), 64'(q.size() == DEPTH));
            chk("drained",   64'(bus.drained_o),   64'(q.size() == 0 && !m_we));
            chk("fwd_hit",   64'(bus.fwd_hit_o),   64'(e_hit));
            chk("fwd_data",  64'(bus.fwd_data_o),  64'(e_fd));
            chk("proto_err", 64'(bus.proto_err_o), 64'(m_perr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wb_we_i    = en;
        bus.wb_waddr_i = a;
        bus.wb_wdata_i = d;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [1:0] src);
        chk({tag, "_we"},   64'(bus.csr_we_o),    64'(we));
        chk({tag, "_addr"}, 64'(bus.csr_waddr_o), 64'(a));
        chk({tag, "_data"}, 64'(bus.csr_wdata_o), 64'(d));
        chk({tag, "_src"},  64'(bus.grant_src_o), 64'(src));
    endtask

    int burst;

    initial begin
        bus.trap_we_i = 0; bus.trap_waddr_i = '0; bus.trap_wdata_i = '0; bus.trap_busy_i = 0;
        wb(1'b0, '0, '0);
        bus.rd_addr_i = '0;
        cyc(); cyc();
        chk_out("rst", 1'b0, '0, '0, 2'b00);
        chk("rst_ready",   64'(bus.wb_ready_o),  64'd1);
        chk("rst_drained", 64'(bus.drained_o),   64'd1);
        chk("rst_stall",   64'(bus.stall_req_o), 64'd0);
        chk("rst_perr",    64'(bus.proto_err_o), 64'd0);
        rst = 1'b0;
        check_en = 1'b1;
        cyc();

        // Direct WB issue when idle
        wb(1'b1, 12'h305, 32'h8000_0100);
        cyc();
        wb(1'b0, '0, '0);
        chk_out("wb_direct", 1'b1, 12'h305, 32'h8000_0100, 2'b10);
        cyc();
        chk("wb_direct_drained", 64'(bus.drained_o), 64'd1);

        // Trap and WB collide: trap first, WB from buffer next
        bus.trap_we_i = 1; bus.trap_waddr_i = 12'h341; bus.trap_wdata_i = 32'h8000_0040;
        wb(1'b1, 12'h300, 32'h8);
        cyc();
        bus.trap_we_i = 0;
        wb(1'b0, '0, '0);
        chk_out("collide_trap", 1'b1, 12'h341, 32'h8000_0040, 2'b01);
        chk("collide_drained", 64'(bus.drained_o), 64'd0);
        cyc();
        chk_out("collide_buf", 1'b1, 12'h300, 32'h8, 2'b11);
        cyc();
        chk("collide_drained2", 64'(bus.drained_o), 64'd1);

        // Forwarding of two buffered writes to the same CSR
        bus.trap_busy_i = 1;
        wb(1'b1, 12'h300, 32'h8);
        cyc();
        wb(1'b1, 12'h300, 32'h88);
        cyc();
        wb(1'b0, '0, '0);
        bus.rd_addr_i = 12'h300;
        #1;
        chk("fwd_young_hit",  64'(bus.fwd_hit_o),  64'd1);
        chk("fwd_young_data", 64'(bus.fwd_data_o), 64'h88);
        bus.rd_addr_i = 12'h304;
        #1;
        chk("fwd_miss_hit",  64'(bus.fwd_hit_o),  64'd0);
        chk("fwd_miss_data", 64'(bus.fwd_data_o), 64'd0);
        bus.trap_busy_i = 0;
        cyc();
        chk_out("fwd_pop0", 1'b1, 12'h300, 32'h8, 2'b11);
        cyc();
        chk_out("fwd_pop1", 1'b1, 12'h300, 32'h88, 2'b11);
        cyc();

        // Long trap with overflow attempt
        bus.trap_busy_i = 1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) wb(1'b1, 12'h340 + 12'(k), 32'h100 + 32'(k));
            else       wb(1'b0, '0, '0);
            if (k == 2) begin
                chk("full_ready", 64'(bus.wb_ready_o),  64'd0);
                chk("full_stall", 64'(bus.stall_req_o), 64'd1);
            end
            cyc();
            chk("trap_hold_we", 64'(bus.csr_we_o), 64'd0);
        end
        chk("perr_set", 64'(bus.proto_err_o), 64'd1);
        bus.trap_busy_i = 0;
        cyc();
        chk_out("trap_end0", 1'b1, 12'h340, 32'h100, 2'b11);
        cyc();
        chk_out("trap_end1", 1'b1, 12'h341, 32'h101, 2'b11);
        cyc();
        chk("trap_end_idle", 64'(bus.csr_we_o), 64'd0);

        // Push and pop every cycle across pointer wrap
        bus.trap_busy_i = 1;
        wb(1'b1, 12'h7AF, 32'hF);
        cyc();
        bus.trap_busy_i = 0;
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            wb(1'b1, 12'h7A0 + 12'(k), 32'(k));
            cyc();
            chk("pp_addr", 64'(bus.csr_waddr_o), (k == 0) ? 64'h7AF : 64'(12'h7A0 + 12'(k - 1)));
            chk("pp_src",  64'(bus.grant_src_o), 64'd3);
            chk("pp_cnt",  64'({bus.wb_ready_o, bus.stall_req_o, bus.drained_o}), 64'b100);
        end
        wb(1'b0, '0, '0);
        cyc();
        chk("pp_last", 64'(bus.csr_waddr_o), 64'h7A4);
        cyc();

        // Reset in the middle of a drain with two entries held
        bus.trap_busy_i = 1;
        wb(1'b1, 12'h310, 32'h1);
        cyc();
        wb(1'b1, 12'h311, 32'h2);
        cyc();
        wb(1'b0, '0, '0);
        bus.trap_busy_i = 0;
        chk("pre_rst_stall", 64'(bus.stall_req_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, '0, '0, 2'b00);
        chk("async_rst_drained", 64'(bus.drained_o), 64'd1);
        chk("async_rst_ready",   64'(bus.wb_ready_o), 64'd1);
        chk("async_rst_perr",    64'(bus.proto_err_o), 64'd0);
        cyc();
        chk_out("rst_hold", 1'b0, '0, '0, 2'b00);
        rst = 1'b0;
        cyc();
        chk("post_rst_drained", 64'(bus.drained_o), 64'd1);

        // Randomized traffic
        burst = 0;
        for (int n = 0; n < 800; n++) begin
            bus.trap_we_i    = ($urandom_range(0, 99) < 12);
            bus.trap_waddr_i = 12'h300 + 12'($urandom_range(0, 3));
            bus.trap_wdata_i = $urandom;
            if (burst == 0 && $urandom_range(0, 99) < 8)
                burst = $urandom_range(1, 6);
            bus.trap_busy_i = (burst > 0);
            if (burst > 0) burst--;
            wb(($urandom_range(0, 99) < 55) && (q.size() != DEPTH || $urandom_range(0, 99) < 5),
               12'h300 + 12'($urandom_range(0, 3)), $urandom);
            bus.rd_addr_i = 12'h300 + 12'($urandom_range(0, 4));
            cyc();
        end
        bus.trap_we_i = 0; bus.trap_busy_i = 0;
        wb(1'b0, '0, '0);
        for (int n = 0; n < 4; n++) cyc();
        chk("final_drained", 64'(bus.drained_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
